// File: rtl/irq_trap_sequencer_if.sv
// Trap-sequencer bus: interrupt sources, CSR views and pipeline control.
// master = the sequencer, slave = the pipeline/CSR side.
interface irq_trap_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            irq_ext_i;
  logic            irq_sw_i;
  logic            irq_tmr_i;
  logic            mstatus_mie_i;
  logic [2:0]      mie_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;
  logic [XLEN-1:0] pc_s1_i;
  logic            valid_s1_i;
  logic            stall_i;
  logic            mret_i;

  logic            flush_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            csr_we_o;
  logic [XLEN-1:0] mepc_o;
  logic [XLEN-1:0] mcause_o;
  logic            mie_clear_o;
  logic            mie_restore_o;
  logic [2:0]      irq_ack_o;
  logic            busy_o;

  modport master (
    input  irq_ext_i, irq_sw_i, irq_tmr_i, mstatus_mie_i, mie_i, mtvec_i,
           mepc_i, pc_s1_i, valid_s1_i, stall_i, mret_i,
    output flush_o, redirect_o, redirect_pc_o, csr_we_o, mepc_o, mcause_o,
           mie_clear_o, mie_restore_o, irq_ack_o, busy_o
  );

  modport slave (
    output irq_ext_i, irq_sw_i, irq_tmr_i, mstatus_mie_i, mie_i, mtvec_i,
           mepc_i, pc_s1_i, valid_s1_i, stall_i, mret_i,
    input  flush_o, redirect_o, redirect_pc_o, csr_we_o, mepc_o, mcause_o,
           mie_clear_o, mie_restore_o, irq_ack_o, busy_o
  );
endinterface

// File: rtl/irq_trap_sequencer.sv
// Machine-mode interrupt/mret sequencer for the 3-stage core.
// Optional IRQ_SYNC_EN: 2-flop synchronizers on the raw interrupt inputs.
module irq_trap_sequencer #(
  parameter int unsigned    XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  irq_trap_sequencer_if.master bus
);

  localparam int unsigned CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_EXT = CODE_W'(11);
  localparam logic [CODE_W-1:0] CODE_SW  = CODE_W'(3);
  localparam logic [CODE_W-1:0] CODE_TMR = CODE_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_FLUSH,
    S_T_SAVE,
    S_T_JUMP,
    S_R_JUMP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]        w_irq_raw;
  logic [2:0]        w_irq_vec;
  logic [2:0]        w_pending;
  logic              w_take_irq;
  logic              w_take_ret;
  logic              w_capture;
  logic [CODE_W-1:0] w_sel_code;
  logic [2:0]        w_sel_ack;

  logic [XLEN-1:0]   r_epc;
  logic [CODE_W-1:0] r_code;

  logic [XLEN-1:0]   w_base;
  logic [XLEN-1:0]   w_vec_target;

  logic              w_flush_nxt;
  logic              w_redirect_nxt;
  logic [XLEN-1:0]   w_redirect_pc_nxt;
  logic              w_csr_we_nxt;
  logic [XLEN-1:0]   w_mepc_nxt;
  logic [XLEN-1:0]   w_mcause_nxt;
  logic              w_mie_clear_nxt;
  logic              w_mie_restore_nxt;
  logic [2:0]        w_ack_nxt;
  logic              w_busy_nxt;

  logic              r_flush;
  logic              r_redirect;
  logic [XLEN-1:0]   r_redirect_pc;
  logic              r_csr_we;
  logic [XLEN-1:0]   r_mepc;
  logic [XLEN-1:0]   r_mcause;
  logic              r_mie_clear;
  logic              r_mie_restore;
  logic [2:0]        r_ack;
  logic              r_busy;

  assign w_irq_raw = {bus.irq_ext_i, bus.irq_sw_i, bus.irq_tmr_i};

`ifdef IRQ_SYNC_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  // Two-stage synchronizer for the asynchronous level sources.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_irq_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_vec = r_sync2;
`else
  assign w_irq_vec = w_irq_raw;
`endif

  assign w_pending  = w_irq_vec & bus.mie_i;
  assign w_take_irq = bus.mstatus_mie_i & (|w_pending) & bus.valid_s1_i & ~bus.stall_i;
  assign w_take_ret = bus.mret_i & bus.valid_s1_i & ~bus.stall_i;

  // Fixed priority: external > software > timer.
  always_comb begin
    w_sel_code = '0;
    w_sel_ack  = '0;
    if (w_pending[2]) begin
      w_sel_code = CODE_EXT;
      w_sel_ack  = 3'b100;
    end else if (w_pending[1]) begin
      w_sel_code = CODE_SW;
      w_sel_ack  = 3'b010;
    end else if (w_pending[0]) begin
      w_sel_code = CODE_TMR;
      w_sel_ack  = 3'b001;
    end
  end

  // Vectored mode adds 4*cause to the aligned base; wraps mod 2^XLEN.
  assign w_base       = {bus.mtvec_i[XLEN-1:2], 2'b00};
  assign w_vec_target = (bus.mtvec_i[1:0] == 2'b01) ? (w_base + (XLEN'(r_code) << 2)) : w_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the output values the next state will present.
  always_comb begin
    w_state_nxt       = r_state;
    w_capture         = 1'b0;
    w_flush_nxt       = 1'b0;
    w_redirect_nxt    = 1'b0;
    w_redirect_pc_nxt = RESET_VEC;
    w_csr_we_nxt      = 1'b0;
    w_mepc_nxt        = r_mepc;
    w_mcause_nxt      = r_mcause;
    w_mie_clear_nxt   = 1'b0;
    w_mie_restore_nxt = 1'b0;
    w_ack_nxt         = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_take_ret) begin
          w_state_nxt = S_R_JUMP;
        end else if (w_take_irq) begin
          w_state_nxt = S_T_FLUSH;
          w_capture   = 1'b1;
        end
      end
      S_T_FLUSH: w_state_nxt = S_T_SAVE;
      S_T_SAVE:  w_state_nxt = S_T_JUMP;
      S_T_JUMP:  w_state_nxt = S_IDLE;
      S_R_JUMP:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase

    unique case (w_state_nxt)
      S_T_FLUSH: begin
        w_flush_nxt = 1'b1;
        w_ack_nxt   = w_sel_ack;
      end
      S_T_SAVE: begin
        w_csr_we_nxt    = 1'b1;
        w_mie_clear_nxt = 1'b1;
        w_mepc_nxt      = r_epc;
        w_mcause_nxt    = {1'b1, {(XLEN-1-CODE_W){1'b0}}, r_code};
      end
      S_T_JUMP: begin
        w_flush_nxt       = 1'b1;
        w_redirect_nxt    = 1'b1;
        w_redirect_pc_nxt = w_vec_target;
      end
      S_R_JUMP: begin
        w_flush_nxt       = 1'b1;
        w_redirect_nxt    = 1'b1;
        w_mie_restore_nxt = 1'b1;
        w_redirect_pc_nxt = {bus.mepc_i[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Cause and epc are frozen at acceptance; later source changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_epc  <= '0;
      r_code <= '0;
    end else if (w_capture) begin
      r_epc  <= bus.pc_s1_i;
      r_code <= w_sel_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= RESET_VEC;
      r_csr_we      <= 1'b0;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mie_clear   <= 1'b0;
      r_mie_restore <= 1'b0;
      r_ack         <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_flush       <= w_flush_nxt;
      r_redirect    <= w_redirect_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_csr_we      <= w_csr_we_nxt;
      r_mepc        <= w_mepc_nxt;
      r_mcause      <= w_mcause_nxt;
      r_mie_clear   <= w_mie_clear_nxt;
      r_mie_restore <= w_mie_restore_nxt;
      r_ack         <= w_ack_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign bus.flush_o       = r_flush;
  assign bus.redirect_o    = r_redirect;
  assign bus.redirect_pc_o = r_redirect_pc;
  assign bus.csr_we_o      = r_csr_we;
  assign bus.mepc_o        = r_mepc;
  assign bus.mcause_o      = r_mcause;
  assign bus.mie_clear_o   = r_mie_clear;
  assign bus.mie_restore_o = r_mie_restore;
  assign bus.irq_ack_o     = r_ack;
  assign bus.busy_o        = r_busy;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Bench for irq_trap_sequencer: cycle-indexed expectation timeline plus
// hand-computed directed checks. Honours IRQ_SYNC_EN for source latency.
module tb_irq_trap_sequencer;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0080;
  localparam int MAXC          = 2048;
`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk;
  logic reset;

  irq_trap_sequencer_if #(.XLEN(XLEN)) bus ();

  irq_trap_sequencer #(.XLEN(XLEN), .RESET_VEC(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  int free_at = 0;

  // Expected timeline: index = cycle number after the n-th rising edge.
  bit          e_flush  [MAXC+4];
  bit          e_redir  [MAXC+4];
  bit          e_csr    [MAXC+4];
  bit          e_rest   [MAXC+4];
  bit          e_busy   [MAXC+4];
  bit          e_zero   [MAXC+4];
  bit   [2:0]  e_ack    [MAXC+4];
  logic [31:0] e_pc     [MAXC+4];
  logic [31:0] e_mepc   [MAXC+4];
  logic [31:0] e_mcause [MAXC+4];

  logic [31:0] h_mepc   = '0;
  logic [31:0] h_mcause = '0;
  logic [2:0]  ms1 = '0;
  logic [2:0]  ms2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Trap entry timeline from the spec's rules, evaluated at each rising edge.
  always @(posedge clk) begin : model
    int n;
    int code;
    logic [2:0] raw, eff, hit, ack;
    logic [31:0] tgt;
    n   = cyc + 1;
    raw = {bus.irq_ext_i, bus.irq_sw_i, bus.irq_tmr_i};
    eff = (SL != 0) ? ms2 : raw;
    if (n < MAXC) begin
      if (reset) begin
        for (int k = n; k < MAXC + 4; k++) begin
          e_flush[k] = 0; e_redir[k] = 0; e_csr[k] = 0; e_rest[k] = 0;
          e_busy[k] = 0; e_zero[k] = 0; e_ack[k] = '0;
        end
        e_zero[n] = 1;
        free_at   = n;
        ms1 = '0;
        ms2 = '0;
      end else begin
        if (cyc >= free_at && bus.valid_s1_i && !bus.stall_i) begin
          hit = eff & bus.mie_i;
          if (bus.mret_i) begin
            e_redir[n] = 1; e_flush[n] = 1; e_rest[n] = 1; e_busy[n] = 1;
            e_pc[n]    = bus.mepc_i & ~32'd1;
            free_at    = n + 1;
          end else if (bus.mstatus_mie_i && hit != 3'b000) begin
            if (hit[2])      begin code = 11; ack = 3'b100; end
            else if (hit[1]) begin code = 3;  ack = 3'b010; end
            else             begin code = 7;  ack = 3'b001; end
            tgt = bus.mtvec_i & ~32'd3;
            if (bus.mtvec_i[1:0] == 2'b01) tgt = tgt + 32'(4 * code);
            e_flush[n] = 1; e_ack[n] = ack; e_busy[n] = 1;
            e_csr[n+1] = 1; e_busy[n+1] = 1;
            e_mepc[n+1]   = bus.pc_s1_i;
            e_mcause[n+1] = 32'h8000_0000 + 32'(code);
            e_flush[n+2] = 1; e_redir[n+2] = 1; e_busy[n+2] = 1; e_pc[n+2] = tgt;
            free_at = n + 3;
          end
        end
        ms2 = ms1;
        ms1 = raw;
      end
    end
    cyc = n;
  end

  // Every-cycle comparison against the timeline.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (e_zero[cyc]) begin h_mepc = '0; h_mcause = '0; end
      if (e_csr[cyc])  begin h_mepc = e_mepc[cyc]; h_mcause = e_mcause[cyc]; end
      chk("flush",       32'(bus.flush_o),       32'(e_flush[cyc]));
      chk("redirect",    32'(bus.redirect_o),    32'(e_redir[cyc]));
      chk("redirect_pc", bus.redirect_pc_o,      e_redir[cyc] ? e_pc[cyc] : RV);
      chk("csr_we",      32'(bus.csr_we_o),      32'(e_csr[cyc]));
      chk("mie_clear",   32'(bus.mie_clear_o),   32'(e_csr[cyc]));
      chk("mie_restore", 32'(bus.mie_restore_o), 32'(e_rest[cyc]));
      chk("irq_ack",     32'(bus.irq_ack_o),     32'(e_ack[cyc]));
      chk("busy",        32'(bus.busy_o),        32'(e_busy[cyc]));
      chk("mepc",        bus.mepc_o,             h_mepc);
      chk("mcause",      bus.mcause_o,           h_mcause);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_irq();
    bus.irq_ext_i = 0; bus.irq_sw_i = 0; bus.irq_tmr_i = 0; bus.mret_i = 0;
  endtask

  typedef struct {
    logic [2:0]  irq;
    logic [2:0]  mie;
    logic        mret;
    logic [31:0] mtvec;
    logic [31:0] pc;
    logic [31:0] mepc;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clr_irq();
    bus.mstatus_mie_i = 1; bus.mie_i = 3'b111; bus.valid_s1_i = 1; bus.stall_i = 0;
    bus.mtvec_i = 32'h200; bus.mepc_i = '0; bus.pc_s1_i = '0;
    tick(3);
    reset = 0;
    tick(2);
    @(negedge clk);
    chk("rst_pc",   bus.redirect_pc_o, RV);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);

    // Timer only, direct mode.
    bus.pc_s1_i = 32'h100; bus.mtvec_i = 32'h200; bus.irq_tmr_i = 1;
    tick(1); bus.irq_tmr_i = 0; tick(SL);
    @(negedge clk);
    chk("t1_flush", 32'(bus.flush_o), 32'd1);
    chk("t1_ack",   32'(bus.irq_ack_o), 32'd1);
    @(negedge clk);
    chk("t1_csr",    32'(bus.csr_we_o), 32'd1);
    chk("t1_mepc",   bus.mepc_o, 32'h100);
    chk("t1_mcause", bus.mcause_o, 32'h8000_0007);
    @(negedge clk);
    chk("t1_redir", bus.redirect_pc_o, 32'h200);
    tick(6);

    // All sources, vectored mode.
    bus.pc_s1_i = 32'h300; bus.mtvec_i = 32'h201;
    bus.irq_ext_i = 1; bus.irq_sw_i = 1; bus.irq_tmr_i = 1;
    tick(1); clr_irq(); tick(SL);
    @(negedge clk);
    chk("t2_ack", 32'(bus.irq_ack_o), 32'd4);
    @(negedge clk);
    chk("t2_mcause", bus.mcause_o, 32'h8000_000B);
    @(negedge clk);
    chk("t2_redir", bus.redirect_pc_o, 32'h22C);
    tick(6);

    // mret wins over a pending timer.
    bus.mepc_i = 32'h104; bus.mret_i = 1; bus.irq_tmr_i = 1;
    tick(1); clr_irq();
    @(negedge clk);
    chk("t3_pc",   bus.redirect_pc_o, 32'h104);
    chk("t3_rest", 32'(bus.mie_restore_o), 32'd1);
    chk("t3_ack",  32'(bus.irq_ack_o), 32'd0);
    chk("t3_csr",  32'(bus.csr_we_o), 32'd0);
    tick(8);

    // Stall holds off acceptance; taken right after release.
    bus.mtvec_i = 32'h200; bus.irq_tmr_i = 1; bus.stall_i = 1;
    repeat (3) begin
      tick(1);
      @(negedge clk);
      chk("t4_stall_busy", 32'(bus.busy_o), 32'd0);
    end
    bus.stall_i = 0;
    tick(1); bus.irq_tmr_i = 0;
    @(negedge clk);
    chk("t4_flush", 32'(bus.flush_o), 32'd1);
    tick(8);

    // Global mask, invalid slot, per-source mask: never taken.
    bus.mstatus_mie_i = 0; bus.irq_tmr_i = 1;
    repeat (3) begin tick(1); @(negedge clk); chk("t5_mie", 32'(bus.busy_o), 32'd0); end
    bus.irq_tmr_i = 0; tick(4); bus.mstatus_mie_i = 1;
    bus.valid_s1_i = 0; bus.irq_ext_i = 1;
    repeat (3) begin tick(1); @(negedge clk); chk("t5_valid", 32'(bus.busy_o), 32'd0); end
    bus.irq_ext_i = 0; tick(4); bus.valid_s1_i = 1;
    bus.mie_i = 3'b110; bus.irq_tmr_i = 1;
    repeat (3) begin tick(1); @(negedge clk); chk("t5_mask", 32'(bus.busy_o), 32'd0); end
    bus.irq_tmr_i = 0; tick(4); bus.mie_i = 3'b111;

    // Reset during the CSR commit cycle.
    bus.pc_s1_i = 32'h400; bus.irq_sw_i = 1;
    tick(1); clr_irq(); tick(SL); tick(1);
    @(negedge clk);
    chk("t6_in_save", 32'(bus.csr_we_o), 32'd1);
    reset = 1;
    tick(1); reset = 0;
    @(negedge clk);
    chk("t6_busy",   32'(bus.busy_o), 32'd0);
    chk("t6_pc",     bus.redirect_pc_o, RV);
    chk("t6_mcause", bus.mcause_o, 32'd0);
    @(negedge clk);
    chk("t6_noredir", 32'(bus.redirect_o), 32'd0);
    tick(4);

    // One-cycle external pulse: flush latency depends on synchronizers.
    bus.irq_ext_i = 1;
    tick(1); bus.irq_ext_i = 0;
    repeat (SL) begin
      @(negedge clk);
      chk("t7_early", 32'(bus.flush_o), 32'd0);
      tick(1);
    end
    @(negedge clk);
    chk("t7_flush", 32'(bus.flush_o), 32'd1);
    tick(8);

    // Directed table, checked through the timeline.
    tbl[0] = '{3'b100, 3'b111, 1'b0, 32'hFFFF_FFFD, 32'h0000_0500, 32'h0};
    tbl[1] = '{3'b010, 3'b111, 1'b0, 32'h0000_1001, 32'h0000_0600, 32'h0};
    tbl[2] = '{3'b011, 3'b101, 1'b0, 32'h0000_2000, 32'h0000_0700, 32'h0};
    tbl[3] = '{3'b000, 3'b111, 1'b1, 32'h0000_0200, 32'h0000_0800, 32'h0000_0105};
    tbl[4] = '{3'b110, 3'b011, 1'b0, 32'h0000_3001, 32'h0000_0900, 32'h0};
    tbl[5] = '{3'b101, 3'b000, 1'b0, 32'h0000_0200, 32'h0000_0A00, 32'h0};
    for (int i = 0; i < 6; i++) begin
      {bus.irq_ext_i, bus.irq_sw_i, bus.irq_tmr_i} = tbl[i].irq;
      bus.mie_i = tbl[i].mie; bus.mret_i = tbl[i].mret;
      bus.mtvec_i = tbl[i].mtvec; bus.pc_s1_i = tbl[i].pc; bus.mepc_i = tbl[i].mepc;
      tick(1); clr_irq();
      tick(10);
    end

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
